cpu_obi_arbiter: RTL and testbench
==================================

# cpu_obi_arbiter

Parametrised OBI arbiter that merges the data (or instruction) ports of `NUM_CORES` CPU subsystems onto a single OBI manager port toward the system bus. It is the multi-hart successor of the single-core CPU-to-bus path. It adds three things that path lacks:
- round-robin arbitration;
- request locking that preserves OBI address stability;
- an in-order ID FIFO that routes responses back to the issuing core, with up to `MAX_OUTSTANDING` transactions in flight.

## Interface
Parameters:
- `NUM_CORES`, default 2: number of core-side OBI subordinate ports; legal range 1..16.
- `MAX_OUTSTANDING`, default 2: ID FIFO depth, i.e. the maximum number of granted transactions not yet answered; legal range 1..8.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `core_req_i`  in  `NUM_CORES` x `obi_req_t`  per-core request: `req`, `we`, `be`, `addr`, `wdata`.
- `core_resp_o`  out  `NUM_CORES` x `obi_resp_t`  per-core response: `gnt`, `rvalid`, `rdata`.
- `bus_req_o`  out  `obi_req_t`  merged request toward the bus.
- `bus_resp_i`  in  `obi_resp_t`  bus response.
- `outstanding_o`  out  `$clog2(MAX_OUTSTANDING+1)`  current ID FIFO occupancy.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
Registered state:
- `rr_ptr_q`: round-robin priority pointer.
- `lock_q` and `lock_idx_q`: request lock.
- ID FIFO: `MAX_OUTSTANDING` entries of `$clog2(NUM_CORES)` bits, with read pointer, write pointer and count.
- `err_q`.

Arbitration:
- Winner is the first requesting core at or after `rr_ptr_q`, wrapping modulo `NUM_CORES`.
- When `lock_q`=1 the winner is `lock_idx_q` regardless of other requests.

Issue:
- `bus_req_o.req` = winner exists AND FIFO not full.
- The remaining `bus_req_o` fields are the winner's fields; they are all-zero when there is no winner.
- A full FIFO blocks issue even if `bus_resp_i.rvalid` pops in the same cycle (conservative, no bypass).

Lock state machine (UNLOCKED / LOCKED):
- UNLOCKED -> LOCKED when `bus_req_o.req`=1 and `bus_resp_i.gnt`=0. Capture the winner into `lock_idx_q`.
- LOCKED -> UNLOCKED on `bus_resp_i.gnt`=1.
- This guarantees the bus sees stable `addr`/`we`/`be`/`wdata` until grant.

Grant:
- `core_resp_o[i].gnt` = `bus_resp_i.gnt` AND `bus_req_o.req` AND (winner == i).
- On grant, push the winner index into the FIFO and set `rr_ptr_q` = (winner + 1) mod `NUM_CORES`.

Response:
- On `bus_resp_i.rvalid`, pop the FIFO head.
- `core_resp_o[head].rvalid`=1; all other cores see `rvalid`=0.
- `rdata` is broadcast to every core.

Simultaneous push and pop: count is unchanged and both pointers advance.

Errors:
- `err_q` sets on `rvalid` with an empty FIFO; that pop is suppressed and no core sees `rvalid`.
- `err_q` also sets on `gnt` while `bus_req_o.req`=0.
- `err_q` clears only on reset.

Case `NUM_CORES`=1: the index width is forced to 1 and the arbiter degenerates to a pass-through with outstanding limiting.

## Timing
- Reset values: `rr_ptr_q`=0, `lock_q`=0, FIFO empty, `outstanding_o`=0, `err_o`=0.
- With no requests, `bus_req_o` is all-zero.
- Request path (`core_req_i` -> `bus_req_o`) is combinational, 0 cycles added.
- Grant path (`bus_resp_i.gnt` -> `core_resp_o.gnt`) is combinational.
- `rvalid`/`rdata` routing is combinational from `bus_resp_i` and the FIFO head.
- Throughput: one grant per cycle while the FIFO is not full.
- `outstanding_o` updates the cycle after each grant or `rvalid`.
- Fairness: a continuously requesting core is granted within `NUM_CORES` grants.
- Reset mid-transaction clears the lock and the FIFO immediately. A later `rvalid` for a pre-reset transaction then sets `err_o`.

## Test plan
- **Single-core pass-through.** `NUM_CORES`=2; core0 reads `0x100` while `gnt` is tied high and `rvalid` arrives one cycle later.
  - Expect `bus_req_o.addr`=`0x100`, `core_resp_o[0].gnt`=1 in the same cycle, `core_resp_o[0].rvalid`=1 with the bus `rdata`, and `core_resp_o[1].rvalid`=0.
- **Round-robin.** Both cores request continuously with `gnt` always 1.
  - Expect grants alternating 0,1,0,1 starting from core0.
- **Lock.** Core1 requests `addr` `0x200` with `gnt`=0 for 3 cycles, while core0 raises `req` in cycle 2.
  - Expect `bus_req_o.addr` to stay `0x200` through all 3 cycles.
  - After core1's grant, core0 is granted next.
- **Outstanding limit.** `MAX_OUTSTANDING`=2; three back-to-back requests with `rvalid` withheld.
  - Expect 2 grants, `outstanding_o`=2, and `bus_req_o.req`=0.
  - One `rvalid` -> the third request is granted the following cycle.
- **Response routing order.** Grant core1, then core0; return two `rvalid` with `rdata` `0xA`, then `0xB`.
  - Expect core1 receives `0xA` and core0 receives `0xB`.
- **Error.** `rvalid` with an empty FIFO.
  - Expect `err_o`=1 from the next cycle, it stays 1, and no core sees `rvalid`.
  - Assert `rst_ni`=0 -> `err_o`=0.

Source files
------------

// File: rtl/cpu_obi_arbiter.sv
// cpu_obi_arbiter: merges the OBI ports of NUM_CORES CPU subsystems onto one
// OBI manager port toward the system bus.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   core_req_i      per-core OBI request  (req, we, be, addr, wdata)
//   core_resp_o     per-core OBI response (gnt, rvalid, rdata)
//   bus_req_o       merged request toward the bus
//   bus_resp_i      bus response
//   outstanding_o   number of granted transactions still awaiting rvalid
//   err_o           sticky protocol error (rvalid with nothing outstanding,
//                   or gnt without a request); cleared only by reset
// Round-robin arbitration, request locking while a request waits for gnt
// (keeps addr/we/be/wdata stable), and an in-order ID FIFO that routes each
// rvalid back to the core that issued the request.

package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cpu_obi_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned NUM_CORES       = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  obi_req_t  [NUM_CORES-1:0]            core_req_i,
  output obi_resp_t [NUM_CORES-1:0]            core_resp_o,
  output obi_req_t                             bus_req_o,
  input  obi_resp_t                            bus_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_state_e;

  lock_state_e                              lock_state_q, lock_state_d;
  logic [IDX_W-1:0]                         lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]                         rr_ptr_q, rr_ptr_d;
  logic [MAX_OUTSTANDING-1:0][IDX_W-1:0]    fifo_q, fifo_d;
  logic [PTR_W-1:0]                         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]                         count_q, count_d;
  logic                                     err_q, err_d;

  logic             lock_q;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  int unsigned      cand;
  int unsigned      nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == MAX_OUTSTANDING - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  assign lock_q     = (lock_state_q == LOCKED);
  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Winner: locked core if a request is pending grant, otherwise the first
  // requester at or after the round-robin pointer (wrapping).
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (lock_q) begin
      win_valid = 1'b1;
      win_idx   = lock_idx_q;
    end else begin
      for (int unsigned off = 0; off < NUM_CORES; off++) begin
        cand = 32'(rr_ptr_q) + off;
        if (cand >= NUM_CORES) cand = cand - NUM_CORES;
        if (!win_valid && core_req_i[cand].req) begin
          win_valid = 1'b1;
          win_idx   = IDX_W'(cand);
        end
      end
    end
  end

  // Full FIFO blocks issue even when a pop happens this cycle (no bypass).
  assign issue = win_valid && !fifo_full;
  assign push  = issue && bus_resp_i.gnt;
  assign pop   = bus_resp_i.rvalid && !fifo_empty;

  always_comb begin
    bus_req_o = '0;
    if (win_valid) bus_req_o = core_req_i[win_idx];
    bus_req_o.req = issue;
  end

  always_comb begin
    core_resp_o = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_resp_o[i].gnt    = push && (win_idx == IDX_W'(i));
      core_resp_o[i].rvalid = pop && (head == IDX_W'(i));
      core_resp_o[i].rdata  = bus_resp_i.rdata;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    rr_ptr_d     = rr_ptr_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    err_d        = err_q;
    nxt          = 0;

    unique case (lock_state_q)
      UNLOCKED: begin
        if (issue && !bus_resp_i.gnt) begin
          lock_state_d = LOCKED;
          lock_idx_d   = win_idx;
        end
      end
      LOCKED: begin
        if (bus_resp_i.gnt) lock_state_d = UNLOCKED;
      end
      default: lock_state_d = UNLOCKED;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = win_idx;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      nxt              = 32'(win_idx) + 1;
      if (nxt >= NUM_CORES) nxt = 0;
      rr_ptr_d         = IDX_W'(nxt);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if ((bus_resp_i.rvalid && fifo_empty) || (bus_resp_i.gnt && !issue)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_state_q <= UNLOCKED;
      lock_idx_q   <= '0;
      rr_ptr_q     <= '0;
      fifo_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cpu_obi_arbiter.sv
module tb_cpu_obi_arbiter;
  import obi_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  obi_req_t  [1:0]       core_req_i;
  obi_resp_t [1:0]       core_resp_o;
  obi_req_t              bus_req_o;
  obi_resp_t             bus_resp_i;
  logic [1:0]            outstanding_o;
  logic                  err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  cpu_obi_arbiter #(
    .NUM_CORES      (2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_resp_o  (core_resp_o),
    .bus_req_o    (bus_req_o),
    .bus_resp_i   (bus_resp_i),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_g0;
    logic        e_g1;
    logic        e_v0;
    logic        e_v1;
    logic [1:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r0, logic [31:0] a0, logic r1, logic [31:0] a1,
                              logic gnt, logic rv, logic [31:0] rd,
                              logic e_req, logic [31:0] e_addr,
                              logic e_g0, logic e_g1, logic e_v0, logic e_v1,
                              logic [1:0] e_out, logic e_err);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_v0 = e_v0; v.e_v1 = e_v1;
    v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                       input logic gnt, input logic rv, input logic [31:0] rd);
    core_req_i[0] = '{req: r0, we: 1'b0, be: 4'hF, addr: a0, wdata: ~a0};
    core_req_i[1] = '{req: r1, we: 1'b0, be: 4'hF, addr: a1, wdata: ~a1};
    bus_resp_i    = '{gnt: gnt, rvalid: rv, rdata: rd};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset / idle
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           0, 0,      0, 0, 0, 0, 0, 0));
    // round-robin, both requesting, gnt high; rvalid drains one per cycle
    vecs.push_back(mk(1, 'h10, 1, 'h14, 1, 0, 0,     1, 'h10,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h10, 1, 'h14, 1, 1, 'hA0,  1, 'h14,   0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 'h10, 1, 'h14, 1, 1, 'hA1,  1, 'h10,   1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 'h10, 1, 'h14, 1, 1, 'hA2,  1, 'h14,   0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'hA3,        0, 0,      0, 0, 0, 1, 1, 0));
    // single-core pass-through
    vecs.push_back(mk(1, 'h100, 0, 0, 1, 0, 0,       1, 'h100,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h5555,      0, 0,      0, 0, 1, 0, 1, 0));
    // response routing: core1 then core0 granted, rdata 0xA then 0xB
    vecs.push_back(mk(0, 0, 1, 'h400, 1, 0, 0,       1, 'h400,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h500, 0, 0, 1, 0, 0,       1, 'h500,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'hA,         0, 0,      0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'hB,         0, 0,      0, 0, 1, 0, 1, 0));
    // one core1 transaction to bring the pointer back to core0
    vecs.push_back(mk(0, 0, 1, 'h600, 1, 0, 0,       1, 'h600,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'hC,         0, 0,      0, 0, 0, 1, 1, 0));
    // lock: core1 held at 0x200 while gnt low, core0 joins; pointer favours core0
    vecs.push_back(mk(0, 0, 1, 'h200, 0, 0, 0,       1, 'h200,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h300, 1, 'h200, 0, 0, 0,   1, 'h200,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h300, 1, 'h200, 0, 0, 0,   1, 'h200,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h300, 1, 'h200, 1, 0, 0,   1, 'h200,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h300, 1, 'h204, 1, 0, 0,   1, 'h300,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h11,        0, 0,      0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h22,        0, 0,      0, 0, 1, 0, 1, 0));
    // outstanding limit: two grants fill the FIFO, third waits for an rvalid
    vecs.push_back(mk(1, 'h700, 1, 'h704, 1, 0, 0,   1, 'h704,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h700, 1, 'h704, 1, 0, 0,   1, 'h700,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 'h708, 0, 0, 0, 0, 0,       0, 'h708,  0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 'h708, 0, 0, 0, 1, 'h33,    0, 'h708,  0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(1, 'h708, 0, 0, 1, 0, 0,       1, 'h708,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h44,        0, 0,      0, 0, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h55,        0, 0,      0, 0, 1, 0, 1, 0));
    // rvalid with empty FIFO: no core sees it, err sticks from next cycle
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h66,        0, 0,      0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           0, 0,      0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           0, 0,      0, 0, 0, 0, 0, 1));

    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[k]) begin
      vec_t v;
      string s;
      v = vecs[k];
      @(negedge clk_i);
      drive(v.r0, v.a0, v.r1, v.a1, v.gnt, v.rv, v.rd);
      #1;
      s = $sformatf("v%0d", k);
      check({s, "_bus_req"},   32'(bus_req_o.req),         32'(v.e_req));
      check({s, "_bus_addr"},  bus_req_o.addr,             v.e_addr);
      check({s, "_bus_wdata"}, bus_req_o.wdata,            (v.e_addr == 0) ? 32'h0 : ~v.e_addr);
      check({s, "_gnt0"},      32'(core_resp_o[0].gnt),    32'(v.e_g0));
      check({s, "_gnt1"},      32'(core_resp_o[1].gnt),    32'(v.e_g1));
      check({s, "_rvalid0"},   32'(core_resp_o[0].rvalid), 32'(v.e_v0));
      check({s, "_rvalid1"},   32'(core_resp_o[1].rvalid), 32'(v.e_v1));
      check({s, "_rdata0"},    core_resp_o[0].rdata,       v.rd);
      check({s, "_rdata1"},    core_resp_o[1].rdata,       v.rd);
      check({s, "_outst"},     32'(outstanding_o),         32'(v.e_out));
      check({s, "_err"},       32'(err_o),                 32'(v.e_err));
    end

    // reset clears the sticky error immediately
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_outst", 32'(outstanding_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // reset mid-transaction: FIFO cleared, late rvalid flags an error
    @(negedge clk_i);
    drive(1, 'h900, 0, 0, 1, 0, 0);
    #1;
    check("mid_gnt0", 32'(core_resp_o[0].gnt), 32'h1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mid_outst_before", 32'(outstanding_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    check("mid_outst_after", 32'(outstanding_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 'h77);
    #1;
    check("mid_rvalid0", 32'(core_resp_o[0].rvalid), 32'h0);
    check("mid_rvalid1", 32'(core_resp_o[1].rvalid), 32'h0);
    check("mid_err_same", 32'(err_o), 32'h0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mid_err_next", 32'(err_o), 32'h1);

    // gnt without a request is also a protocol error
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    check("gnt_noreq_err_same", 32'(err_o), 32'h0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("gnt_noreq_err_next", 32'(err_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
